// File: rtl/ddr_test_pkg.sv
// Shared types and helpers for the DDR burst write/read-back tester:
// FSM state encoding, the beat pattern and burst address stepping.
package ddr_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_GAP     = 3'd2,
    S_RD_CMD  = 3'd3,
    S_RD_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam int PAT_W = 32;

  // Beat k of a run carries seed + k, wrapping at 32 bits.
  function automatic logic [PAT_W-1:0] pattern_word(input logic [31:0] seed,
                                                    input logic [31:0] index);
    return seed + index;
  endfunction

  // Callers truncate the result to the address width, which gives the wrap.
  function automatic logic [63:0] burst_addr_inc(input logic [63:0] addr,
                                                 input logic [63:0] burst_len);
    return addr + burst_len;
  endfunction

endpackage

// File: rtl/ddr_pattern_gen.sv
// Expands the 32-bit seed+index pattern word to the full Avalon data width.
module ddr_pattern_gen
  import ddr_test_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [31:0]       seed,
  input  logic [31:0]       index,
  output logic [DATA_W-1:0] data
);

  logic [PAT_W-1:0] word_s;

  assign word_s = pattern_word(seed, index);

  // Replicate the word across the bus; a partial top slice keeps the word's low bits.
  for (genvar g = 0; g < DATA_W; g++) begin : g_fill
    assign data[g] = word_s[g % PAT_W];
  end

endmodule

// File: rtl/ddr_burst_verify_engine.sv
// Avalon-MM burst write / read-back tester: writes a seeded pattern, waits a gap,
// reads every burst back, compares each beat and reports pass/errors/timeout.
module ddr_burst_verify_engine
  import ddr_test_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 25,
  parameter int BURST_LEN  = 8,
  parameter int NUM_BURSTS = 16,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [31:0]           seed,
  output logic [ADDR_W-1:0]     avl_address,
  output logic                  avl_write,
  output logic                  avl_read,
  output logic                  avl_beginbursttransfer,
  output logic [7:0]            avl_burstcount,
  output logic [DATA_W/8-1:0]   avl_byteenable,
  output logic [DATA_W-1:0]     avl_writedata,
  input  logic [DATA_W-1:0]     avl_readdata,
  input  logic                  avl_readdatavalid,
  input  logic                  avl_waitrequest_n,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic                  timeout_err
);

  state_t              state_r, state_s;
  logic [31:0]         seed_r, seed_s;
  logic [ADDR_W-1:0]   base_r, base_s, addr_r, addr_s;
  logic [ADDR_W-1:0]   first_r, first_s, mm_addr_r, mm_addr_s;
  logic [15:0]         burst_r, burst_s, err_r, err_s;
  logic [7:0]          beat_r, beat_s;
  logic [31:0]         wr_idx_r, wr_idx_s, rd_idx_r, rd_idx_s;
  logic [31:0]         gap_r, gap_s, to_r, to_s;
  logic                write_r, write_s, read_r, read_s, bbt_r, bbt_s;
  logic                busy_r, busy_s, done_r, done_s, pass_r, pass_s;
  logic                tmo_r, tmo_s, mm_r, mm_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s, exp_rd_s;
  logic                run_start_s, last_beat_s, last_burst_s;
  logic [ADDR_W-1:0]   next_burst_addr_s;

  // Write side looks at the next index so avl_writedata is registered with the beat.
  ddr_pattern_gen #(.DATA_W(DATA_W)) u_wr_pat (
    .seed  (seed_s),
    .index (wr_idx_s),
    .data  (wdata_s)
  );

  ddr_pattern_gen #(.DATA_W(DATA_W)) u_rd_pat (
    .seed  (seed_r),
    .index (rd_idx_r),
    .data  (exp_rd_s)
  );

  assign run_start_s       = (state_r == S_IDLE) && start;
  assign last_beat_s       = (beat_r == 8'(BURST_LEN - 1));
  assign last_burst_s      = (burst_r == 16'(NUM_BURSTS - 1));
  assign next_burst_addr_s = ADDR_W'(burst_addr_inc(64'(addr_r), 64'(BURST_LEN)));

  // Error bookkeeping, one cycle behind the sampled beat.
  always_comb begin
    err_s   = err_r;
    first_s = first_r;
    if (run_start_s) begin
      err_s   = 16'h0000;
      first_s = {ADDR_W{1'b0}};
    end else if (mm_r) begin
      if (err_r != 16'hFFFF) begin
        err_s = err_r + 16'd1;
      end else begin
        err_s = err_r;
      end
      if (err_r == 16'h0000) begin
        first_s = mm_addr_r;
      end else begin
        first_s = first_r;
      end
    end else begin
      err_s   = err_r;
      first_s = first_r;
    end
  end

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_s   = state_r;
    seed_s    = seed_r;
    base_s    = base_r;
    addr_s    = addr_r;
    burst_s   = burst_r;
    beat_s    = beat_r;
    wr_idx_s  = wr_idx_r;
    rd_idx_s  = rd_idx_r;
    gap_s     = gap_r;
    to_s      = to_r;
    write_s   = 1'b0;
    read_s    = 1'b0;
    bbt_s     = 1'b0;
    busy_s    = busy_r;
    done_s    = 1'b0;
    pass_s    = pass_r;
    tmo_s     = tmo_r;
    mm_s      = 1'b0;
    mm_addr_s = mm_addr_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s  = S_WR;
          seed_s   = seed;
          base_s   = base_addr;
          addr_s   = base_addr;
          burst_s  = 16'd0;
          beat_s   = 8'd0;
          wr_idx_s = 32'd0;
          rd_idx_s = 32'd0;
          write_s  = 1'b1;
          bbt_s    = 1'b1;
          busy_s   = 1'b1;
          pass_s   = 1'b0;
          tmo_s    = 1'b0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WR: begin
        write_s = 1'b1;
        bbt_s   = bbt_r;
        if (avl_waitrequest_n) begin
          wr_idx_s = wr_idx_r + 32'd1;
          if (last_beat_s) begin
            beat_s = 8'd0;
            if (last_burst_s) begin
              state_s = S_GAP;
              write_s = 1'b0;
              bbt_s   = 1'b0;
              addr_s  = base_r;
              burst_s = 16'd0;
              gap_s   = 32'd0;
            end else begin
              addr_s  = next_burst_addr_s;
              burst_s = burst_r + 16'd1;
              bbt_s   = 1'b1;
            end
          end else begin
            beat_s = beat_r + 8'd1;
            bbt_s  = 1'b0;
          end
        end else begin
          state_s = S_WR;
        end
      end
      S_GAP: begin
        if (gap_r + 32'd1 >= 32'(GAP_CYCLES)) begin
          state_s = S_RD_CMD;
          read_s  = 1'b1;
          bbt_s   = 1'b1;
        end else begin
          gap_s = gap_r + 32'd1;
        end
      end
      S_RD_CMD: begin
        read_s = 1'b1;
        bbt_s  = 1'b1;
        if (avl_waitrequest_n) begin
          state_s = S_RD_DATA;
          read_s  = 1'b0;
          bbt_s   = 1'b0;
          beat_s  = 8'd0;
          to_s    = 32'd0;
        end else begin
          state_s = S_RD_CMD;
        end
      end
      S_RD_DATA: begin
        if (avl_readdatavalid) begin
          to_s      = 32'd0;
          mm_s      = (avl_readdata != exp_rd_s);
          mm_addr_s = addr_r + ADDR_W'(beat_r);
          rd_idx_s  = rd_idx_r + 32'd1;
          if (last_beat_s) begin
            beat_s = 8'd0;
            if (last_burst_s) begin
              state_s = S_FIN;
            end else begin
              state_s = S_RD_CMD;
              burst_s = burst_r + 16'd1;
              addr_s  = next_burst_addr_s;
              read_s  = 1'b1;
              bbt_s   = 1'b1;
            end
          end else begin
            beat_s = beat_r + 8'd1;
          end
        end else if (to_r + 32'd1 >= 32'(TIMEOUT)) begin
          tmo_s   = 1'b1;
          state_s = S_FIN;
        end else begin
          to_s = to_r + 32'd1;
        end
      end
      S_FIN: begin
        // err_s already folds in the compare of the final beat.
        state_s = S_IDLE;
        done_s  = 1'b1;
        busy_s  = 1'b0;
        pass_s  = (err_s == 16'h0000) && !tmo_r;
      end
      default: begin
        state_s = S_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      seed_r    <= 32'd0;
      base_r    <= {ADDR_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      first_r   <= {ADDR_W{1'b0}};
      mm_addr_r <= {ADDR_W{1'b0}};
      burst_r   <= 16'd0;
      err_r     <= 16'd0;
      beat_r    <= 8'd0;
      wr_idx_r  <= 32'd0;
      rd_idx_r  <= 32'd0;
      gap_r     <= 32'd0;
      to_r      <= 32'd0;
      write_r   <= 1'b0;
      read_r    <= 1'b0;
      bbt_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      tmo_r     <= 1'b0;
      mm_r      <= 1'b0;
      wdata_r   <= {DATA_W{1'b0}};
    end else begin
      state_r   <= state_s;
      seed_r    <= seed_s;
      base_r    <= base_s;
      addr_r    <= addr_s;
      first_r   <= first_s;
      mm_addr_r <= mm_addr_s;
      burst_r   <= burst_s;
      err_r     <= err_s;
      beat_r    <= beat_s;
      wr_idx_r  <= wr_idx_s;
      rd_idx_r  <= rd_idx_s;
      gap_r     <= gap_s;
      to_r      <= to_s;
      write_r   <= write_s;
      read_r    <= read_s;
      bbt_r     <= bbt_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      pass_r    <= pass_s;
      tmo_r     <= tmo_s;
      mm_r      <= mm_s;
      wdata_r   <= wdata_s;
    end
  end

  assign avl_address            = addr_r;
  assign avl_write              = write_r;
  assign avl_read               = read_r;
  assign avl_beginbursttransfer = bbt_r;
  assign avl_burstcount         = 8'(BURST_LEN);
  assign avl_byteenable         = {(DATA_W/8){1'b1}};
  assign avl_writedata          = wdata_r;
  assign busy                   = busy_r;
  assign done                   = done_r;
  assign pass                   = pass_r;
  assign err_cnt                = err_r;
  assign first_err_addr         = first_r;
  assign timeout_err            = tmo_r;

endmodule
